usart_rx: RTL and testbench

- 8N1 asynchronous serial receiver: the receive end of the link whose transmitter drives tx at 115200 baud from the 16 MHz system clock.
- Synchronises the rx pin, detects the start bit and samples each bit at mid-period.
- Delivers each byte to the consumer over a valid/ack handshake, with framing-error and overrun reporting.
- Sits beside the transmitter in the top-level serial path; its output feeds the command/data consumer.

---
 rtl/usart_rx_pkg.sv | 23 ++
 rtl/usart_rx_sync.sv | 28 ++
 rtl/usart_rx.sv | 141 ++++++++++++++
 tb/tb_usart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_rx_pkg.sv
// usart_rx_pkg
//   Shared definitions for the asynchronous serial receiver: FSM state
//   encoding, default clock/line rates and the bit-period divider formula.
//   No ports (package).
package usart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } usart_state_t;

  localparam int unsigned DEFAULT_CLK_FREQ  = 16000000;
  localparam int unsigned DEFAULT_BAUD_RATE = 115200;

  // Clock cycles per bit; integer division truncates (16 MHz / 115200 = 138).
  function automatic int unsigned clk_divider(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/usart_rx_sync.sv
// usart_rx_sync
//   Two-flop synchroniser for the asynchronous rx pin. Both flops reset to 1
//   so that the idle-high line does not look like a start bit after reset.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   d      in   asynchronous input
//   q      out  synchronised output (2 cycles of latency)
module usart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] chain_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      chain_reg <= 2'b11;
    end else begin
      chain_reg <= {chain_reg[0], d};
    end
  end

  assign q = chain_reg[1];

endmodule

// File: rtl/usart_rx.sv
// usart_rx
//   8N1 asynchronous serial receiver. Detects the start bit on the
//   synchronised line, samples every bit at mid-period and hands each byte to
//   the consumer over a level-valid / ack-strobe handshake.
// Ports:
//   clock          in   system clock, all logic on posedge
//   reset          in   synchronous active-high reset
//   rx             in   asynchronous serial line, idle high
//   bytereceived   out  last correctly framed byte (LSB received first)
//   received       out  high while bytereceived holds an unconsumed byte
//   ack            in   consumer read strobe, clears received and overrun
//   framing_error  out  one-cycle pulse when the stop-bit sample is 0
//   overrun        out  sticky: a byte completed while received was high
//   rx_led         out  high while the receiver is busy with a frame
module usart_rx
  import usart_rx_pkg::*;
#(
  parameter int unsigned fsm_clk_freq = DEFAULT_CLK_FREQ,
  parameter int unsigned baud_rate    = DEFAULT_BAUD_RATE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] bytereceived,
  output logic       received,
  input  logic       ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_led
);

  localparam int unsigned fsm_clk_divider = clk_divider(fsm_clk_freq, baud_rate);
  localparam int unsigned half_divider    = fsm_clk_divider / 2;

  // A counter loaded with N ticks N+1 edges later, hence the -1.
  localparam logic [15:0] full_load = 16'(fsm_clk_divider - 1);
  localparam logic [15:0] half_load = 16'(half_divider - 1);

  logic         rx_s;
  usart_state_t state_reg;
  logic [15:0]  count_reg;
  logic [2:0]   bit_idx_reg;
  logic [7:0]   shift_reg;
  logic         tick;

  usart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick = (count_reg == 16'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= 16'd0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      bytereceived  <= 8'h00;
      received      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      rx_led        <= 1'b0;
    end else begin
      framing_error <= 1'b0;

      // Handshake; a byte completing on this same edge overrides below.
      if (ack && received) begin
        received <= 1'b0;
      end
      if (ack) begin
        overrun <= 1'b0;
      end

      // Counter parks at zero while idle; every load below overrides this.
      if (!tick) begin
        count_reg <= count_reg - 16'd1;
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            count_reg <= half_load;
            state_reg <= START_BIT;
            rx_led    <= 1'b1;
          end
        end

        START_BIT: begin
          if (tick) begin
            if (!rx_s) begin
              count_reg   <= full_load;
              bit_idx_reg <= 3'd0;
              state_reg   <= DATA;
            end else begin
              // Line went back high before mid-start-bit: treat as a glitch.
              state_reg <= IDLE;
              rx_led    <= 1'b0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            shift_reg   <= {rx_s, shift_reg[7:1]};
            count_reg   <= full_load;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP_BIT;
            end
          end
        end

        STOP_BIT: begin
          if (tick) begin
            // Leave at mid-stop-bit so a following start edge is not missed.
            state_reg <= IDLE;
            rx_led    <= 1'b0;
            if (rx_s) begin
              bytereceived <= shift_reg;
              received     <= 1'b1;
              if (received && !ack) begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          rx_led    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx
//   Self-checking bench for usart_rx: a table of single frames followed by
//   hand-written sequences for back-to-back, glitch, overrun and reset cases.
module tb_usart_rx;

  localparam int BIT_CYC = 138;
  localparam int LATENCY = 1314;  // rx fall (negedge) to received visible

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] bytereceived;
  logic       received;
  logic       framing_error;
  logic       overrun;
  logic       rx_led;

  usart_rx dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .bytereceived  (bytereceived),
    .received      (received),
    .ack           (ack),
    .framing_error (framing_error),
    .overrun       (overrun),
    .rx_led        (rx_led)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic       prev_rcv = 1'b0;
  int         rise_cnt = 0;
  int         fe_cnt   = 0;
  int         led_cnt  = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] rise_val[$];

  always @(negedge clock) begin
    if (received && !prev_rcv) begin
      rise_cnt++;
      rise_val.push_back(bytereceived);
      rise_cyc = cyc;
    end
    if (framing_error) fe_cnt++;
    if (rx_led) led_cnt++;
    prev_rcv = received;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cnt = 0;
    fe_cnt   = 0;
    led_cnt  = 0;
    rise_val.delete();
  endtask

  // Called on a negedge; returns on the negedge after the last stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nstop);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (BIT_CYC) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CYC) @(negedge clock);
    end
    rx = stop;
    repeat (BIT_CYC) @(negedge clock);
    rx = 1'b1;
    if (nstop > 1) repeat (BIT_CYC * (nstop - 1)) @(negedge clock);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_rise(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      if (rise_cnt >= k) ok = 1'b1;
    end
    check("rise_timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         nstop;
    logic [7:0] exp_byte;
    logic       exp_rcv;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;

    vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 1'b1, 0};
    vecs[1] = '{8'hA5, 1'b1, 2, 8'hA5, 1'b1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1, 8'h3C, 1'b1, 0};
    vecs[3] = '{8'hF0, 1'b0, 1, 8'h3C, 1'b0, 1};
    vecs[4] = '{8'h00, 1'b1, 2, 8'h00, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b1, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 8'h01, 1'b1, 0};
    vecs[7] = '{8'h80, 1'b1, 1, 8'h80, 1'b1, 0};

    // Reset state.
    repeat (5) @(negedge clock);
    check("reset_byte", 32'(bytereceived), 32'h00);
    check("reset_received", 32'(received), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_led", 32'(rx_led), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Table of single frames, each acked afterwards.
    for (int v = 0; v < 8; v++) begin
      clear_mon();
      send_frame(vecs[v].d, vecs[v].stop, vecs[v].nstop);
      repeat (200) @(negedge clock);
      $display("frame %0d: sent %02h stop=%0b -> byte=%02h received=%0b fe_pulses=%0d",
               v, vecs[v].d, vecs[v].stop, bytereceived, received, fe_cnt);
      check($sformatf("vec%0d_rises", v), 32'(rise_cnt), 32'(vecs[v].exp_rcv));
      check($sformatf("vec%0d_byte", v), 32'(bytereceived), 32'(vecs[v].exp_byte));
      check($sformatf("vec%0d_received", v), 32'(received), 32'(vecs[v].exp_rcv));
      check($sformatf("vec%0d_fe", v), 32'(fe_cnt), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
      if (vecs[v].exp_rcv) begin
        check($sformatf("vec%0d_latency", v), 32'(rise_cyc - fall_cyc), 32'(LATENCY));
      end
      pulse_ack();
      check($sformatf("vec%0d_ack_clears", v), 32'(received), 32'd0);
    end

    // Back-to-back frames, each acked 5 cycles after received rises.
    clear_mon();
    fork
      begin
        send_frame(8'hA5, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1);
      end
      begin
        for (int k = 1; k <= 2; k++) begin
          wait_rise(k, ok);
          if (ok) begin
            repeat (5) @(negedge clock);
            ack = 1'b1;
            @(negedge clock);
            ack = 1'b0;
          end
        end
      end
    join
    repeat (20) @(negedge clock);
    $display("back-to-back: rises=%0d overrun=%0b", rise_cnt, overrun);
    check("b2b_rises", 32'(rise_cnt), 32'd2);
    if (rise_val.size() == 2) begin
      check("b2b_first", 32'(rise_val[0]), 32'hA5);
      check("b2b_second", 32'(rise_val[1]), 32'h3C);
    end else begin
      check("b2b_queue", 32'(rise_val.size()), 32'd2);
    end
    check("b2b_overrun", 32'(overrun), 32'd0);
    check("b2b_received", 32'(received), 32'd0);

    // Glitch: 20 low cycles is a false start.
    clear_mon();
    rx = 1'b0;
    repeat (20) @(negedge clock);
    rx = 1'b1;
    repeat (200) @(negedge clock);
    $display("glitch: led_cycles=%0d rises=%0d fe=%0d", led_cnt, rise_cnt, fe_cnt);
    check("glitch_led_cycles", 32'(led_cnt), 32'd69);
    check("glitch_rises", 32'(rise_cnt), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    check("glitch_led_idle", 32'(rx_led), 32'd0);

    // Overrun: two frames with no ack.
    clear_mon();
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    repeat (20) @(negedge clock);
    $display("overrun: byte=%02h received=%0b overrun=%0b", bytereceived, received, overrun);
    check("ovr_byte", 32'(bytereceived), 32'h22);
    check("ovr_received", 32'(received), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_rises", 32'(rise_cnt), 32'd1);
    pulse_ack();
    check("ovr_ack_received", 32'(received), 32'd0);
    check("ovr_ack_flag", 32'(overrun), 32'd0);
    check("ovr_ack_byte", 32'(bytereceived), 32'h22);

    // Reset in the middle of data bit 4, held until the frame has ended.
    clear_mon();
    fork
      send_frame(8'h81, 1'b1, 1);
      begin
        repeat (BIT_CYC * 5 + 69) @(negedge clock);
        check("midrst_busy", 32'(rx_led), 32'd1);
        reset = 1'b1;
      end
    join
    check("midrst_byte", 32'(bytereceived), 32'h00);
    check("midrst_led", 32'(rx_led), 32'd0);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    $display("mid-frame reset: rises=%0d fe=%0d", rise_cnt, fe_cnt);
    check("midrst_rises", 32'(rise_cnt), 32'd0);
    check("midrst_fe", 32'(fe_cnt), 32'd0);
    check("midrst_received", 32'(received), 32'd0);
    send_frame(8'h7E, 1'b1, 1);
    repeat (20) @(negedge clock);
    $display("after reset: byte=%02h received=%0b", bytereceived, received);
    check("postrst_byte", 32'(bytereceived), 32'h7E);
    check("postrst_received", 32'(received), 32'd1);
    check("postrst_latency", 32'(rise_cyc - fall_cyc), 32'(LATENCY));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
